// File: rtl/collision_pkg.sv
// Shared types and index helpers for the collision event unit.
// Pair index k encodes (src, tgt) as k = src*NUM_TGT + tgt.
package collision_pkg;

    localparam int DEF_NUM_SRC = 3;
    localparam int DEF_NUM_TGT = 4;
    localparam int DEF_FRAME_W = 4;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pair_idx(input int src, input int tgt, input int num_tgt);
        return src * num_tgt + tgt;
    endfunction

    function automatic int pair_src(input int idx, input int num_tgt);
        return idx / num_tgt;
    endfunction

    function automatic int pair_tgt(input int idx, input int num_tgt);
        return idx % num_tgt;
    endfunction

    // Event record for the default game configuration.
    typedef struct packed {
        logic [width_of(DEF_NUM_SRC)-1:0] src;
        logic [width_of(DEF_NUM_TGT)-1:0] tgt;
        logic [DEF_FRAME_W-1:0]           frame;
    } evt_t;

endpackage

// File: rtl/collision_event_unit_fifo.sv
// Synchronous FIFO with valid/ready on both sides and an occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Transfer on either side happens exactly when valid & ready at the clock edge.
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = (count != CNT_W'(DEPTH)) | pop;
    assign push      = in_valid & in_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/collision_event_unit.sv
// Shot/target collision detector: one hit per pair per frame, pulses, frame snapshot,
// and a queue of encoded hit events drained lowest pair index first.
module collision_event_unit
    import collision_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int NUM_TGT    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_W    = 4
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            startOfFrame,
    input  logic                            enable,
    input  logic [NUM_SRC-1:0]              drawing_request_src,
    input  logic [NUM_TGT-1:0]              drawing_request_tgt,
    output logic [NUM_SRC*NUM_TGT-1:0]      hit_pulse,
    output logic [NUM_SRC-1:0]              src_hit_pulse,
    output logic [NUM_SRC*NUM_TGT-1:0]      frame_hits,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [width_of(NUM_SRC)-1:0]    evt_src,
    output logic [width_of(NUM_TGT)-1:0]    evt_tgt,
    output logic [FRAME_W-1:0]              evt_frame,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [7:0]                      drop_cnt
);

    localparam int NP    = NUM_SRC * NUM_TGT;
    localparam int SRC_W = width_of(NUM_SRC);
    localparam int TGT_W = width_of(NUM_TGT);
    localparam int IDX_W = width_of(NP);
    localparam int ADD_W = $clog2(NP + 1);

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [TGT_W-1:0]   tgt;
        logic [FRAME_W-1:0] frame;
    } event_t;

    logic [NP-1:0]      overlap, seen, first, pending, grant_vec, coalesced;
    logic [NUM_SRC-1:0] src_any;
    logic [FRAME_W-1:0] frame_cnt;
    logic [IDX_W-1:0]   grant_idx;
    logic [ADD_W-1:0]   drop_add;
    logic [8:0]         drop_sum;
    logic               fifo_in_ready, push;
    event_t             wr_evt, head_evt;

    always_comb begin
        overlap = '0;
        src_any = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_TGT; j++) begin
                overlap[pair_idx(i, j, NUM_TGT)] = enable & drawing_request_src[i] & drawing_request_tgt[j];
            end
        end
        // In a startOfFrame cycle the old frame's history no longer masks hits.
        first = startOfFrame ? overlap : (overlap & ~seen);
        for (int i = 0; i < NUM_SRC; i++) begin
            src_any[i] = |first[i*NUM_TGT +: NUM_TGT];
        end
    end

    always_comb begin
        grant_vec = pending & (~pending + 1'b1);
        grant_idx = '0;
        for (int k = NP - 1; k >= 0; k--) begin
            if (pending[k]) grant_idx = IDX_W'(k);
        end
        push = (pending != '0) & fifo_in_ready;
        wr_evt.src   = SRC_W'(pair_src(int'(grant_idx), NUM_TGT));
        wr_evt.tgt   = TGT_W'(pair_tgt(int'(grant_idx), NUM_TGT));
        wr_evt.frame = frame_cnt;
    end

    always_comb begin
        coalesced = first & pending;
        drop_add  = '0;
        for (int k = 0; k < NP; k++) begin
            drop_add = drop_add + ADD_W'(coalesced[k]);
        end
        drop_sum = {1'b0, drop_cnt} + 9'(drop_add);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            seen          <= '0;
            pending       <= '0;
            hit_pulse     <= '0;
            src_hit_pulse <= '0;
            frame_hits    <= '0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            seen          <= startOfFrame ? first : (seen | first);
            pending       <= (pending | first) & ~(push ? grant_vec : '0);
            hit_pulse     <= first;
            src_hit_pulse <= src_any;
            drop_cnt      <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (startOfFrame) begin
                frame_hits <= seen;
                frame_cnt  <= frame_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .in_valid  (push),
        .in_ready  (fifo_in_ready),
        .in_data   (wr_evt),
        .out_valid (evt_valid),
        .out_ready (evt_ready),
        .out_data  (head_evt),
        .count     (fifo_count)
    );

    assign evt_src   = head_evt.src;
    assign evt_tgt   = head_evt.tgt;
    assign evt_frame = head_evt.frame;

endmodule

// File: tb/tb_collision_event_unit.sv
// Bench for collision_event_unit: directed scenarios plus random traffic, all compared
// against a pair-array / event-queue reference model.
module tb_collision_event_unit;

    localparam int NS    = 3;
    localparam int NT    = 4;
    localparam int NP    = NS * NT;
    localparam int DEPTH = 8;
    localparam int FW    = 4;
    localparam int W     = 2 + 2 + FW;

    logic          clk = 1'b0;
    logic          resetN, startOfFrame, enable, evt_ready;
    logic [NS-1:0] drawing_request_src;
    logic [NT-1:0] drawing_request_tgt;
    logic [NP-1:0] hit_pulse, frame_hits;
    logic [NS-1:0] src_hit_pulse;
    logic          evt_valid;
    logic [1:0]    evt_src, evt_tgt;
    logic [FW-1:0] evt_frame;
    logic [3:0]    fifo_count;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    collision_event_unit #(
        .NUM_SRC (NS), .NUM_TGT (NT), .FIFO_DEPTH (DEPTH), .FRAME_W (FW)
    ) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .enable              (enable),
        .drawing_request_src (drawing_request_src),
        .drawing_request_tgt (drawing_request_tgt),
        .hit_pulse           (hit_pulse),
        .src_hit_pulse       (src_hit_pulse),
        .frame_hits          (frame_hits),
        .evt_valid           (evt_valid),
        .evt_ready           (evt_ready),
        .evt_src             (evt_src),
        .evt_tgt             (evt_tgt),
        .evt_frame           (evt_frame),
        .fifo_count          (fifo_count),
        .drop_cnt            (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-pair flags, event queue, frame number and drop count.
    bit         m_seen  [NP];
    bit         m_pend  [NP];
    bit         m_hits  [NP];
    bit         m_pulse [NP];
    int         m_frame;
    int         m_drop;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] to_vec(input bit a[NP]);
        logic [NP-1:0] v;
        for (int k = 0; k < NP; k++) v[k] = a[k];
        return v;
    endfunction

    task automatic model_step();
        bit first [NP];
        int grant;
        bit pop;
        int old_frame;
        if (!resetN) begin
            for (int k = 0; k < NP; k++) begin
                m_seen[k] = 0; m_pend[k] = 0; m_hits[k] = 0; m_pulse[k] = 0;
            end
            m_frame = 0;
            m_drop  = 0;
            exp_q.delete();
            return;
        end
        for (int s = 0; s < NS; s++) begin
            for (int t = 0; t < NT; t++) begin
                first[s*NT+t] = enable && drawing_request_src[s] && drawing_request_tgt[t]
                                && (startOfFrame || !m_seen[s*NT+t]);
            end
        end
        pop   = (exp_q.size() > 0) && evt_ready;
        grant = -1;
        if (exp_q.size() < DEPTH || pop) begin
            for (int k = NP - 1; k >= 0; k--) if (m_pend[k]) grant = k;
        end
        old_frame = m_frame;
        for (int k = 0; k < NP; k++) begin
            if (first[k] && m_pend[k] && m_drop < 255) m_drop++;
            m_pulse[k] = first[k];
            if (startOfFrame) begin
                m_hits[k] = m_seen[k];
                m_seen[k] = first[k];
            end else if (first[k]) begin
                m_seen[k] = 1;
            end
            if (first[k]) m_pend[k] = 1;
        end
        if (startOfFrame) m_frame = (m_frame + 1) % (1 << FW);
        if (grant >= 0) m_pend[grant] = 0;
        if (pop) void'(exp_q.pop_front());
        if (grant >= 0) exp_q.push_back({2'(grant / NT), 2'(grant % NT), FW'(old_frame)});
    endtask

    task automatic compare_all();
        logic [NP-1:0] pv;
        logic [NS-1:0] sv;
        pv = to_vec(m_pulse);
        for (int s = 0; s < NS; s++) sv[s] = |pv[s*NT +: NT];
        check("hit_pulse",  hit_pulse,  pv);
        check("src_hit",    src_hit_pulse, sv);
        check("frame_hits", frame_hits, to_vec(m_hits));
        check("fifo_count", fifo_count, exp_q.size());
        check("evt_valid",  evt_valid,  exp_q.size() != 0);
        check("evt_head",   {evt_src, evt_tgt, evt_frame}, (exp_q.size() != 0) ? exp_q[0] : '0);
        check("drop_cnt",   drop_cnt,   m_drop);
    endtask

    // One clock: apply inputs, advance the model across the edge, sample 1 ns after it.
    task automatic cyc(input bit sof, input bit en, input logic [NS-1:0] s,
                       input logic [NT-1:0] t, input bit rdy, input bit rst_n = 1'b1);
        resetN              = rst_n;
        startOfFrame        = sof;
        enable              = en;
        drawing_request_src = s;
        drawing_request_tgt = t;
        evt_ready           = rdy;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic hit_pair(input int k, input bit sof, input bit rdy);
        cyc(sof, 1'b1, NS'(1 << (k / NT)), NT'(1 << (k % NT)), rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int c = 0; c < n; c++) cyc(1'b0, 1'b1, '0, '0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0;
        drawing_request_src = '0; drawing_request_tgt = '0; evt_ready = 1'b0;

        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_drop",  drop_cnt, 0);

        // Repeated overlap of one pair: single pulse, single event.
        cyc(1'b1, 1'b1, '0, '0, 1'b1);
        cyc(1'b0, 1'b1, 3'b010, 4'b0001, 1'b1);
        check("t1_pulse", hit_pulse, 12'h010);
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 3'b010, 4'b0001, 1'b1);
        check("t1_nopulse", hit_pulse, 0);
        idle(3, 1'b1);
        check("t1_drop", drop_cnt, 0);

        // Same pair in two frames, events tagged with frame 0 then 1.
        do_reset();
        hit_pair(4, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b1, 1'b1, '0, '0, 1'b0);
        hit_pair(4, 1'b0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 1'b1, '0, '0, 1'b0);
        check("t2_fh4", frame_hits[4], 1);
        check("t2_count", fifo_count, 2);
        check("t2_frame0", evt_frame, 0);
        idle(1, 1'b1);
        check("t2_frame1", evt_frame, 1);
        idle(2, 1'b1);

        // Three sources on one target in a single pixel.
        cyc(1'b0, 1'b1, 3'b111, 4'b0100, 1'b1);
        check("t3_pulse", hit_pulse, 12'h444);
        idle(5, 1'b1);

        // Overlap during startOfFrame belongs to the new frame.
        cyc(1'b1, 1'b1, NS'(1 << 1), NT'(1 << 1), 1'b1);
        check("t5_pulse", hit_pulse[5], 1);
        check("t5_absent", frame_hits[5], 0);
        idle(2, 1'b1);
        cyc(1'b1, 1'b1, '0, '0, 1'b1);
        check("t5_next", frame_hits[5], 1);
        idle(3, 1'b1);

        // Backpressure: 10 pairs with a stalled consumer, then coalescing and ordered drain.
        do_reset();
        for (int k = 0; k < 10; k++) hit_pair(k, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t4_count", fifo_count, 8);
        check("t4_valid", evt_valid, 1);
        cyc(1'b1, 1'b1, '0, '0, 1'b0);
        hit_pair(8, 1'b0, 1'b0);
        check("t4_drop", drop_cnt, 1);
        for (int n = 0; n < 10; n++) begin
            check("t4_order", {evt_src, evt_tgt}, n);
            idle(1, 1'b1);
        end
        check("t4_empty", fifo_count, 0);

        // Reset discards queued events.
        do_reset();
        for (int k = 0; k < 3; k++) hit_pair(k, 1'b0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 1'b1, '0, '0, 1'b0);
        check("t6_queued", fifo_count, 3);
        cyc(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        check("t6_count", fifo_count, 0);
        check("t6_valid", evt_valid, 0);
        check("t6_fh", frame_hits, 0);

        // Random traffic with bursts of consumer stall.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit stall;
            stall = ((c / 150) % 2) == 1;
            cyc($urandom_range(0, 24) == 0,
                $urandom_range(0, 9) != 0,
                NS'($urandom_range(0, 7) & $urandom_range(0, 7)),
                NT'($urandom_range(0, 15) & $urandom_range(0, 15)),
                stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 999) != 0);
        end
        idle(20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
